// File: rtl/sa_ws_skewed_array.sv
// Weight-stationary systolic GEMM array with built-in input skew and output deskew.
// Define SA_PERF_CNT_EN to add perf_busy_cycles / perf_vectors counters.
module sa_ws_skewed_array #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int W_W   = 8,
  parameter int A_W   = 8,
  parameter int ACC_W = W_W + A_W + $clog2(ROWS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  w_valid,
  input  logic [COLS*W_W-1:0]   w_row,
  output logic                  w_ready,
  output logic                  weights_loaded,
  input  logic                  a_valid,
  input  logic [ROWS*A_W-1:0]   a_vec,
  output logic                  a_ready,
  output logic                  y_valid,
  output logic [COLS*ACC_W-1:0] y_vec,
  output logic                  busy
`ifdef SA_PERF_CNT_EN
  ,
  output logic [31:0]           perf_busy_cycles,
  output logic [31:0]           perf_vectors
`endif
);

  localparam int LAT = ROWS + COLS - 1;
  localparam int CW  = $clog2(ROWS + 1);
  localparam int IW  = $clog2(ROWS + COLS);
  localparam int PW  = W_W + A_W;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_READY
  } state_e;

  state_e         r_state;
  state_e         w_state_nx;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_nx;
  logic [CW-1:0]  w_cnt_inc;
  logic [IW-1:0]  r_inflight;
  logic [LAT-1:0] r_vsr;
  logic           w_w_acc;
  logic           w_a_acc;

  assign a_ready        = (r_state == S_READY);
  assign weights_loaded = (r_state == S_READY);
  assign w_ready        = (r_state != S_READY) ||
                          (r_inflight == '0 && !a_valid);
  assign w_w_acc        = w_valid && w_ready;
  assign w_a_acc        = a_valid && a_ready;
  assign busy           = (r_inflight != '0);
  assign y_valid        = r_vsr[LAT-1];

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_LOAD:  w_cnt_inc = r_cnt + CW'(1);
      default: w_cnt_inc = CW'(1);
    endcase
    if (w_w_acc) begin
      if (w_cnt_inc == CW'(ROWS)) begin
        w_state_nx = S_READY;
        w_cnt_nx   = '0;
      end else begin
        w_state_nx = S_LOAD;
        w_cnt_nx   = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_EMPTY;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Valid bit rides a shift register matching the datapath depth.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inflight <= '0;
      r_vsr      <= '0;
    end else begin
      r_vsr <= {r_vsr[LAT-2:0], w_a_acc};
      if (w_a_acc && !y_valid) begin
        r_inflight <= r_inflight + IW'(1);
      end else if (!w_a_acc && y_valid) begin
        r_inflight <= r_inflight - IW'(1);
      end
    end
  end

  logic signed [A_W-1:0]   w_act  [ROWS][COLS];
  logic signed [W_W-1:0]   w_wt   [ROWS][COLS];
  logic signed [ACC_W-1:0] w_psin [ROWS][COLS];
  logic signed [ACC_W-1:0] w_bot  [COLS];
  logic signed [ACC_W-1:0] w_y    [COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [A_W-1:0] w_a;
    assign w_a = w_a_acc ? a_vec[r*A_W +: A_W] : '0;
    if (r == 0) begin : g_r0
      assign w_act[r][0] = w_a;
    end else begin : g_rn
      logic signed [A_W-1:0] r_s [r];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < r; k++) begin
            r_s[k] <= '0;
          end
        end else begin
          r_s[0] <= w_a;
          for (int k = 1; k < r; k++) begin
            r_s[k] <= r_s[k-1];
          end
        end
      end
      assign w_act[r][0] = r_s[r-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [W_W-1:0]   r_w;
      logic signed [PW-1:0]    w_prod;
      logic signed [ACC_W-1:0] w_sum;

      // Weight rows shift down on every accepted beat.
      if (r == 0) begin : g_wtop
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            r_w <= '0;
          end else if (w_w_acc) begin
            r_w <= w_row[c*W_W +: W_W];
          end
        end
        assign w_psin[r][c] = '0;
      end else begin : g_wsh
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            r_w <= '0;
          end else if (w_w_acc) begin
            r_w <= w_wt[r-1][c];
          end
        end
      end

      assign w_wt[r][c] = r_w;
      assign w_prod     = PW'(w_act[r][c]) * PW'(w_wt[r][c]);
      assign w_sum      = w_psin[r][c] + ACC_W'(w_prod);

      if (c < COLS - 1) begin : g_aright
        logic signed [A_W-1:0] r_a;
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            r_a <= '0;
          end else begin
            r_a <= w_act[r][c];
          end
        end
        assign w_act[r][c+1] = r_a;
      end

      if (r < ROWS - 1) begin : g_pdown
        logic signed [ACC_W-1:0] r_p;
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            r_p <= '0;
          end else begin
            r_p <= w_sum;
          end
        end
        assign w_psin[r+1][c] = r_p;
      end else begin : g_pbot
        assign w_bot[c] = w_sum;
      end
    end
  end

  // Left columns finish early; delay them so all columns land together.
  for (genvar c = 0; c < COLS; c++) begin : g_dsk
    localparam int D = COLS - 1 - c;
    logic signed [ACC_W-1:0] r_y;
    if (D == 0) begin : g_nod
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_y <= '0;
        end else begin
          r_y <= w_bot[c];
        end
      end
    end else begin : g_d
      logic signed [ACC_W-1:0] r_d [D];
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          for (int k = 0; k < D; k++) begin
            r_d[k] <= '0;
          end
          r_y <= '0;
        end else begin
          r_d[0] <= w_bot[c];
          for (int k = 1; k < D; k++) begin
            r_d[k] <= r_d[k-1];
          end
          r_y <= r_d[D-1];
        end
      end
    end
    assign w_y[c] = r_y;
  end

  always_comb begin
    y_vec = '0;
    for (int c = 0; c < COLS; c++) begin
      y_vec[c*ACC_W +: ACC_W] = w_y[c];
    end
  end

`ifdef SA_PERF_CNT_EN
  logic w_load_entry;
  assign w_load_entry = (w_state_nx == S_LOAD) &&
                        (r_state != S_LOAD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_busy_cycles <= '0;
      perf_vectors     <= '0;
    end else if (w_load_entry) begin
      perf_busy_cycles <= '0;
      perf_vectors     <= '0;
    end else begin
      if (busy && perf_busy_cycles != 32'hFFFF_FFFF) begin
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      end
      if (y_valid && perf_vectors != 32'hFFFF_FFFF) begin
        perf_vectors <= perf_vectors + 32'd1;
      end
    end
  end
`endif

endmodule
